// File: rtl/branch_update_ctrl.sv
// Branch prediction bookkeeping: queues predicted branches, trains the predictor on in-order
// resolution, and flushes on mispredict. Optional counters via BRANCH_UPDATE_CTRL_STATS_EN.
module branch_update_ctrl #(
  parameter int unsigned NUM_ENTRIES = 4
) (
  input  logic                             clk,
  input  logic                             reset,
  input  logic                             req_val,
  output logic                             req_rdy,
  input  logic [31:0]                      req_pc,
  output logic                             resp_taken,
  output logic [31:0]                      bp_pc,
  input  logic                             bp_prediction,
  output logic                             bp_update_en,
  output logic                             bp_update_val,
  input  logic                             res_val,
  output logic                             res_rdy,
  input  logic                             res_taken,
  output logic                             mispred,
  output logic [$clog2(NUM_ENTRIES):0]     outstanding,
  output logic [31:0]                      stat_lookups,
  output logic [31:0]                      stat_mispreds
);

  localparam int unsigned PtrW = $clog2(NUM_ENTRIES);
  localparam int unsigned CntW = PtrW + 1;
  localparam logic [CntW-1:0] Full = CntW'(NUM_ENTRIES);

  typedef enum logic [1:0] {StIdle, StUpdate, StRecover} state_e;

  state_e          r_state, w_state_d;
  logic [PtrW-1:0] r_head, r_tail;
  logic [CntW-1:0] r_count;
  logic [31:0]     r_pc [NUM_ENTRIES];
  logic            r_pred [NUM_ENTRIES];
  logic [31:0]     r_upd_pc;
  logic            r_upd_taken, r_upd_mis;

  logic w_idle, w_req_hs, w_res_hs, w_mis;

  assign w_idle      = (r_state == StIdle);
  assign req_rdy     = w_idle && (r_count != Full);
  assign res_rdy     = w_idle && (r_count != '0);
  assign w_req_hs    = req_val && req_rdy;
  assign w_res_hs    = res_val && res_rdy;
  assign w_mis       = (r_pred[r_head] != res_taken);
  assign outstanding = r_count;

  always_comb begin
    w_state_d     = r_state;
    resp_taken    = 1'b0;
    bp_pc         = req_pc;
    bp_update_en  = 1'b0;
    bp_update_val = 1'b0;
    mispred       = 1'b0;
    unique case (r_state)
      StIdle: begin
        resp_taken = bp_prediction;
        if (w_res_hs) w_state_d = StUpdate;
      end
      StUpdate: begin
        bp_update_en  = 1'b1;
        bp_update_val = r_upd_taken;
        bp_pc         = r_upd_pc;
        mispred       = r_upd_mis;
        w_state_d     = r_upd_mis ? StRecover : StIdle;
      end
      StRecover: w_state_d = StIdle;
      default:   w_state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= StIdle;
      r_head      <= '0;
      r_tail      <= '0;
      r_count     <= '0;
      r_upd_pc    <= '0;
      r_upd_taken <= 1'b0;
      r_upd_mis   <= 1'b0;
    end else begin
      r_state <= w_state_d;
      if (w_res_hs) begin
        r_upd_pc    <= r_pc[r_head];
        r_upd_taken <= res_taken;
        r_upd_mis   <= w_mis;
      end
      // A mispredict squashes everything younger, including a same-cycle push.
      if (w_res_hs && w_mis) begin
        r_head  <= '0;
        r_tail  <= '0;
        r_count <= '0;
      end else begin
        if (w_req_hs) r_tail <= r_tail + 1'b1;
        if (w_res_hs) r_head <= r_head + 1'b1;
        case ({w_req_hs, w_res_hs})
          2'b10:   r_count <= r_count + 1'b1;
          2'b01:   r_count <= r_count - 1'b1;
          default: r_count <= r_count;
        endcase
      end
    end
  end

  always_ff @(posedge clk) begin
    if (w_req_hs) begin
      r_pc[r_tail]   <= req_pc;
      r_pred[r_tail] <= bp_prediction;
    end
  end

`ifdef BRANCH_UPDATE_CTRL_STATS_EN
  logic [31:0] r_stat_lookups, r_stat_mispreds;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_stat_lookups  <= '0;
      r_stat_mispreds <= '0;
    end else begin
      if (w_req_hs && (r_stat_lookups != '1)) r_stat_lookups <= r_stat_lookups + 1'b1;
      if ((r_state == StUpdate) && r_upd_mis && (r_stat_mispreds != '1)) begin
        r_stat_mispreds <= r_stat_mispreds + 1'b1;
      end
    end
  end

  assign stat_lookups  = r_stat_lookups;
  assign stat_mispreds = r_stat_mispreds;
`else
  assign stat_lookups  = '0;
  assign stat_mispreds = '0;
`endif

endmodule

// File: doc/branch_update_ctrl.md
BRANCH_UPDATE_CTRL -- requirements
Module: branch_update_ctrl

Interface
REQ-001: The block SHALL have one clock and a synchronous, active-high reset: clk (input, 1) and reset (input, 1).
REQ-002: Parameter NUM_ENTRIES, default 4, SHALL set the outstanding-branch queue depth; legal values are powers of two from 2 to 16.
REQ-003: Port clk SHALL be an input, 1 bit, the rising-edge clock.
REQ-004: Port reset SHALL be an input, 1 bit, the synchronous active-high reset.
REQ-005: Port req_val SHALL be an input, 1 bit, indicating fetch requests a prediction.
REQ-006: Port req_rdy SHALL be an output, 1 bit, indicating the controller accepts the request.
REQ-007: Port req_pc SHALL be an input, 32 bits, the branch PC.
REQ-008: Port resp_taken SHALL be an output, 1 bit, the prediction, valid in the req handshake cycle.
REQ-009: Port bp_pc SHALL be an output, 32 bits, driving the predictor's PC input.
REQ-010: Port bp_prediction SHALL be an input, 1 bit, the predictor's combinational prediction.
REQ-011: Ports bp_update_en and bp_update_val SHALL be outputs, 1 bit each, driving the predictor's update port.
REQ-012: Ports res_val (input, 1), res_rdy (output, 1) and res_taken (input, 1) SHALL form the in-order branch-resolution handshake.
REQ-013: Port mispred SHALL be an output, 1 bit, a one-cycle mispredict pulse.
REQ-014: Port outstanding SHALL be an output, $clog2(NUM_ENTRIES)+1 bits, the queue occupancy.
REQ-015: Ports stat_lookups and stat_mispreds SHALL be outputs, 32 bits each, statistics counters.

Function
REQ-016: A handshake SHALL occur on a rising edge where val and rdy are both 1.
REQ-017: The state machine SHALL have the states IDLE, UPDATE and RECOVER.
REQ-018: In IDLE, req_rdy SHALL equal (outstanding != NUM_ENTRIES), and res_rdy SHALL equal (outstanding != 0).
REQ-019: In UPDATE and RECOVER, req_rdy and res_rdy SHALL both be 0.
REQ-020: In IDLE, bp_pc SHALL equal req_pc, resp_taken SHALL equal bp_prediction, and bp_update_en SHALL be 0.
REQ-021: A req handshake SHALL push {req_pc, bp_prediction} at the tail; tail and head pointers SHALL wrap modulo NUM_ENTRIES.
REQ-022: A res handshake SHALL pop the head entry and latch its PC, res_taken, and (predicted != res_taken); the next state SHALL be UPDATE.
REQ-023: In UPDATE (exactly one cycle), bp_update_en SHALL be 1, bp_update_val SHALL equal the latched res_taken, and bp_pc SHALL equal the latched PC.
REQ-024: In UPDATE, mispred SHALL equal the latched mismatch bit.
REQ-025: Resolve-to-update latency SHALL be exactly one cycle after the res handshake.
REQ-026: UPDATE SHALL go to RECOVER if mismatch, otherwise to IDLE; RECOVER SHALL last one cycle and then go to IDLE.
REQ-027: On a res handshake with mismatch, every remaining entry SHALL be discarded (outstanding becomes 0), including any entry pushed in the same cycle.
REQ-028: For simultaneous req and res handshakes without mismatch, both SHALL be accepted and outstanding SHALL be unchanged.
REQ-029: When full, req_rdy SHALL be 0 even if res_val is 1 (no full-bypass).
REQ-030: When empty, res_rdy SHALL be 0 regardless of req_val.

Reset
REQ-031: Reset SHALL take priority over all other activity at the clock edge.
REQ-032: Reset SHALL force state IDLE, empty pointers, outstanding 0, bp_update_en 0, bp_update_val 0, mispred 0, and stats 0.
REQ-033: A reset asserted during UPDATE or RECOVER SHALL abort it, with no update issued on the following cycle.

Configuration
REQ-034: When macro BRANCH_UPDATE_CTRL_STATS_EN is defined, stat_lookups SHALL count req handshakes and stat_mispreds SHALL count entries into RECOVER.
REQ-035: With BRANCH_UPDATE_CTRL_STATS_EN defined, both counters SHALL saturate at 32'hFFFFFFFF.
REQ-036: When BRANCH_UPDATE_CTRL_STATS_EN is undefined, stat_lookups and stat_mispreds SHALL be constant 0 and no counter registers SHALL exist.

Verification
REQ-037: Reset, then req_val=1, req_pc=0x20C, bp_prediction=0 -> req_rdy=1, resp_taken=0, bp_pc=0x20C; outstanding=1 next cycle.
REQ-038: Push 4 entries with NUM_ENTRIES=4 -> req_rdy=0 and outstanding=4; a 5th req is held until a resolve completes.
REQ-039: Resolve the oldest entry (predicted 0) with res_taken=1 -> the next cycle shows bp_update_en=1, bp_update_val=1, bp_pc equal to the oldest PC, and mispred=1.
REQ-040: After a mispredict, the controller then spends one RECOVER cycle with req_rdy=0, then returns to IDLE with outstanding=0.
REQ-041: Interleave 25 push/resolve pairs with correct predictions -> pointers wrap, mispred is never asserted, and outstanding returns to 0.
REQ-042: Assert reset during UPDATE -> bp_update_en=0 the following cycle, and all outputs are at reset values; with STATS_EN defined, counters read 0.
